universal_shift_register: RTL
=============================

# universal_shift_register

Parametrised multi-bit shift register that generalises the fixed 4-stage, 1-bit delay line to W-bit words and DEPTH stages. Adds per-stage valid tracking, parallel load, rotate and hold modes, a parallel tap of every stage, and a registered occupancy count. Used as a configurable delay line, serial-to-parallel converter or circular buffer in datapath blocks.

## Interface
- W, 8, data word width in bits (W >= 1)
- DEPTH, 4, number of stages (DEPTH >= 2)
- CW, $clog2(DEPTH+1), width of count (derived localparam, not overridable)

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset rst, synchronous, active-high; clock clk
- en  input  1  update enable; 0 forces HOLD regardless of mode
- mode  input  2  operation select: 00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE
- din  input  W  serial word entering stage 0 in SHIFT
- din_valid  input  1  valid flag accompanying din in SHIFT
- pdata  input  DEPTH*W  parallel load data; stage i = pdata[i*W +: W]
- dout  output  W  contents of stage DEPTH-1
- dout_valid  output  1  valid flag of stage DEPTH-1
- pout  output  DEPTH*W  all stages; stage i = pout[i*W +: W]
- count  output  CW  number of stages whose valid flag is set

## Operation
- State: stage[0..DEPTH-1] (W bits each), vld[0..DEPTH-1], count register.
- Reset (rst=1 at edge): all stages 0, all vld 0, count 0. rst overrides en and mode.
- Effective op = HOLD when en=0, otherwise mode.
- HOLD (00): all state unchanged.
- SHIFT (01): stage[0]<=din, vld[0]<=din_valid; stage[i]<=stage[i-1], vld[i]<=vld[i-1] for i=1..DEPTH-1. Old stage[DEPTH-1]/vld[DEPTH-1] discarded.
- LOAD (10): stage[i]<=pdata[i*W +: W] for all i; all vld<=1. din/din_valid ignored.
- ROTATE (11): stage[0]<=stage[DEPTH-1], vld[0]<=vld[DEPTH-1]; stage[i]<=stage[i-1], vld[i]<=vld[i-1]. No data lost; count unchanged.
- count: registered, updated on the same edge as vld, always equal to popcount of the vld state it accompanies (never lags). Range 0..DEPTH.
  - SHIFT: count_next = count + din_valid - vld[DEPTH-1] (both 1 or both 0 -> unchanged).
  - LOAD: count_next = DEPTH.
  - HOLD/ROTATE: unchanged.
- Stage data is stored regardless of valid flag; invalid stages hold whatever was shifted in (0 after reset).
- dout, dout_valid, pout are direct outputs of state registers (no combinational path from inputs).

## Timing
- All outputs change only after a rising clk edge; no input-to-output combinational path.
- SHIFT latency: word on din at edge k (with SHIFT every cycle) appears on dout after edge k+DEPTH-1, i.e. visible in the cycle following the DEPTH-th consecutive SHIFT edge counting its own capture edge.
- Stalled shifts (en=0 or HOLD) extend latency by one cycle each; no data or valid lost.
- LOAD: pout == pdata and count == DEPTH one cycle after the load edge.
- ROTATE: DEPTH consecutive ROTATE edges return every stage to its original value.
- Reset mid-operation: next edge clears everything; first edge with rst=0 performs the selected op on cleared state.
- Boundaries: count saturates naturally at DEPTH in SHIFT when din_valid=1 and vld[DEPTH-1]=1 (stays DEPTH); count stays 0 when shifting din_valid=0 into empty register.

## Test plan
- Reset: rst=1 for 3 edges with random din, mode=01 -> dout=0, dout_valid=0, pout=0, count=0 throughout.
- Delay line (W=8, DEPTH=4): SHIFT every cycle, din=0x11,0x22,0x33,0x44,0x55 all valid -> dout=0x11 after 4th edge, then 0x22, 0x33...; count 1,2,3,4,4; 50 random words matched against a DEPTH-deep reference queue.
- Valid bubbles: SHIFT din_valid pattern 1,0,1,0 then four zeros -> count 1,1,2,2,1,1,0,0; dout_valid mirrors pattern delayed 4 edges.
- Load then rotate: LOAD pdata=0x44_33_22_11 -> pout=0x44332211, count=4; ROTATE once -> pout=0x33221144; 3 more ROTATEs -> 0x44332211, count=4.
- Enable/hold: mid-stream en=0 for 3 cycles with mode=01 and changing din -> pout and count frozen; resume yields original ordering, latency +3.
- Reset mid-stream: after LOAD, assert rst for 1 edge then SHIFT din=0xAA valid -> pout=0x000000AA, count=1.

Source files
------------

// File: rtl/universal_shift_register_if.sv
// +----------------------------------------------------------------------+
// | universal_shift_register_if                                          |
// | Control, data and status bundle for the universal shift register.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface universal_shift_register_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 en;
  logic [1:0]           mode;
  logic [W-1:0]         din;
  logic                 din_valid;
  logic [DEPTH*W-1:0]   pdata;
  logic [W-1:0]         dout;
  logic                 dout_valid;
  logic [DEPTH*W-1:0]   pout;
  logic [CW-1:0]        count;

  modport master (
    output en, mode, din, din_valid, pdata,
    input  dout, dout_valid, pout, count
  );

  modport slave (
    input  en, mode, din, din_valid, pdata,
    output dout, dout_valid, pout, count
  );
endinterface

`default_nettype wire

// File: rtl/universal_shift_register.sv
// +----------------------------------------------------------------------+
// | universal_shift_register                                             |
// | W-bit, DEPTH-stage shift register with hold/shift/load/rotate modes, |
// | per-stage valid flags and a registered occupancy count.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module universal_shift_register #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  universal_shift_register_if.slave     bus
);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] c_MODE_HOLD   = 2'b00;
  localparam logic [1:0] c_MODE_SHIFT  = 2'b01;
  localparam logic [1:0] c_MODE_LOAD   = 2'b10;
  localparam logic [1:0] c_MODE_ROTATE = 2'b11;
  localparam logic [CW-1:0] c_COUNT_FULL = CW'(DEPTH);

  logic [W-1:0]     r_stage [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CW-1:0]    r_count;

  logic [W-1:0]     w_stage_next [DEPTH];
  logic [DEPTH-1:0] w_vld_next;
  logic [CW-1:0]    w_count_next;
  logic [1:0]       w_op;

  assign w_op = bus.en ? bus.mode : c_MODE_HOLD;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_stage_next[i] = r_stage[i];
    end
    w_vld_next   = r_vld;
    w_count_next = r_count;

    case (w_op)
      c_MODE_SHIFT: begin
        w_stage_next[0] = bus.din;
        w_vld_next[0]   = bus.din_valid;
        for (int i = 1; i < DEPTH; i++) begin
          w_stage_next[i] = r_stage[i-1];
          w_vld_next[i]   = r_vld[i-1];
        end
        // Modular arithmetic keeps this exact: the result is always 0..DEPTH.
        w_count_next = r_count + CW'(bus.din_valid) - CW'(r_vld[DEPTH-1]);
      end
      c_MODE_LOAD: begin
        for (int i = 0; i < DEPTH; i++) begin
          w_stage_next[i] = bus.pdata[i*W +: W];
        end
        w_vld_next   = '1;
        w_count_next = c_COUNT_FULL;
      end
      c_MODE_ROTATE: begin
        w_stage_next[0] = r_stage[DEPTH-1];
        w_vld_next[0]   = r_vld[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) begin
          w_stage_next[i] = r_stage[i-1];
          w_vld_next[i]   = r_vld[i-1];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_vld   <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= w_stage_next[i];
      end
      r_vld   <= w_vld_next;
      r_count <= w_count_next;
    end
  end

  assign bus.dout       = r_stage[DEPTH-1];
  assign bus.dout_valid = r_vld[DEPTH-1];
  assign bus.count      = r_count;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_pout
      assign bus.pout[g*W +: W] = r_stage[g];
    end
  endgenerate

endmodule

`default_nettype wire
